// File: rtl/dma_pkg.sv
// Shared DMA definitions: channel state encoding and parameter legality helpers.
package dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain
  } dma_state_e;

  // SRAM read latency the valid pipe supports.
  function automatic bit read_latency_legal(int unsigned lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

  // Return buffer must cover the whole pipe plus headroom for a stalled consumer.
  function automatic bit ret_depth_legal(int unsigned depth, int unsigned lat);
    return depth >= (lat + 2);
  endfunction

endpackage

// File: rtl/fwft_sc_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is visible whenever not empty.
module fwft_sc_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_fire, rd_fire;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign rd_fire   = rd_en_i & (count_q != '0);
  assign wr_fire   = wr_en_i & ((count_q != CntW'(Depth)) | rd_fire);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dma_mem_rd_port.sv
// Memory-side read adapter for the outbound DMA engine: turns address requests into
// fixed-latency SRAM reads and returns data in order through a credit-protected buffer.
// Optional build macro DMA_RD_ADDR_CHECK_EN: out-of-range requests skip the SRAM,
// return zero in order and set the sticky err_addr flag.
module dma_mem_rd_port
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RET_DEPTH    = 8,
  parameter int unsigned MEM_WORDS    = 65536
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  dmaReset,
  input  logic [31:0]           req_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] t0_data,
  output logic                  t0_valid,
  input  logic                  t0_ready,
  output logic                  busy,
  output logic                  err_addr,
  input  logic                  err_clear
);

  localparam int unsigned CredW = $clog2(RET_DEPTH + 1);

  if (!read_latency_legal(READ_LATENCY)) begin : gen_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (!ret_depth_legal(RET_DEPTH, READ_LATENCY)) begin : gen_bad_depth
    $error("RET_DEPTH must be at least READ_LATENCY+2");
  end
  if (64'(MEM_WORDS) > (64'd1 << ADDR_WIDTH)) begin : gen_bad_words
    $error("MEM_WORDS exceeds the address space");
  end

  dma_state_e              state_q, state_d;
  logic [CredW-1:0]        credits_q, credits_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] zero_q, zero_d;
  logic                    accept, pop, oor;
  logic                    buf_wr, buf_empty;
  logic [DATA_WIDTH-1:0]   buf_wdata;

  assign req_ready = (credits_q != '0) & ~dmaReset & (state_q != StDrain) & ~srst;
  assign accept    = req_valid & req_ready;
  assign mem_en    = accept & ~oor;
  assign mem_addr  = req_addr[ADDR_WIDTH-1:0];
  assign t0_valid  = ~buf_empty;
  assign pop       = t0_valid & t0_ready;
  assign busy      = (state_q != StIdle);

  // Words arriving during a flush or drain belong to the aborted transfer.
  assign buf_wr    = vld_q[READ_LATENCY-1] & ~dmaReset & (state_q != StDrain);
  assign buf_wdata = zero_q[READ_LATENCY-1] ? '0 : mem_rdata;

`ifdef DMA_RD_ADDR_CHECK_EN
  logic err_q;

  assign oor      = (req_addr >= MEM_WORDS);
  assign err_addr = err_q;

  // Sticky error; a new out-of-range accept beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (srst) begin
      err_q <= 1'b0;
    end else if (accept && oor) begin
      err_q <= 1'b1;
    end else if (err_clear) begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_inputs;

  assign oor           = 1'b0;
  assign err_addr      = 1'b0;
  assign unused_inputs = err_clear ^ (^req_addr);
`endif

  // Valid/zero pipe tracks each read until its data leaves the SRAM.
  always_comb begin
    vld_d     = vld_q;
    zero_d    = zero_q;
    vld_d[0]  = accept;
    zero_d[0] = accept & oor;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      vld_d[i]  = vld_q[i-1];
      zero_d[i] = zero_q[i-1];
    end
  end

  // Credits count free return-buffer slots, including reads still in flight.
  always_comb begin
    credits_d = credits_q;
    if (dmaReset) begin
      credits_d = CredW'(RET_DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits_d = credits_q - CredW'(1);
        2'b01:   credits_d = credits_q + CredW'(1);
        default: credits_d = credits_q;
      endcase
    end
  end

  // Channel FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dmaReset && (vld_q != '0)) begin
          state_d = StDrain;
        end else if (accept) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (dmaReset) begin
          state_d = (vld_q != '0) ? StDrain : StIdle;
        end else if (!accept && (vld_q == '0) && buf_empty) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (vld_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, credit and pipe registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= StIdle;
      credits_q <= CredW'(RET_DEPTH);
      vld_q     <= '0;
      zero_q    <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      vld_q     <= vld_d;
      zero_q    <= zero_d;
    end
  end

  fwft_sc_fifo #(
    .Depth (RET_DEPTH),
    .Width (DATA_WIDTH)
  ) u_ret_buf (
    .clk_i     (clk),
    .srst_i    (srst | dmaReset),
    .wr_en_i   (buf_wr),
    .wr_data_i (buf_wdata),
    .rd_en_i   (t0_ready),
    .rd_data_o (t0_data),
    .empty_o   (buf_empty)
  );

endmodule

// File: tb/tb_dma_mem_rd_port.sv
// Randomized bench for dma_mem_rd_port against a transaction-level model
// (in-flight read list, return queue, credit count, drain window).
module tb_dma_mem_rd_port;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WORDS = 1024;

`ifdef DMA_RD_ADDR_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic          clk;
  logic          srst;
  logic          dma_reset;
  logic [31:0]   req_addr;
  logic          req_valid;
  logic          req_ready;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] t0_data;
  logic          t0_valid;
  logic          t0_ready;
  logic          busy;
  logic          err_addr;
  logic          err_clear;

  dma_mem_rd_port #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (LAT),
    .RET_DEPTH    (DEPTH),
    .MEM_WORDS    (WORDS)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .dmaReset  (dma_reset),
    .req_addr  (req_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .t0_data   (t0_data),
    .t0_valid  (t0_valid),
    .t0_ready  (t0_ready),
    .busy      (busy),
    .err_addr  (err_addr),
    .err_clear (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // SRAM model: data appears LAT cycles after mem_en; junk otherwise.
  logic [DW-1:0] sram_pipe [LAT];
  always @(posedge clk) begin
    sram_pipe[0] <= (mem_en === 1'b1) ? sram_word(mem_addr) : $urandom();
    for (int i = 1; i < int'(LAT); i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign mem_rdata = sram_pipe[LAT-1];

  typedef struct {
    logic [31:0] data;
    int          exit_cyc;
  } rd_t;

  rd_t         inflight[$];
  logic [31:0] bufq[$];
  int          credits, drain_until, last_accept, cyc;
  bit          busy_m, err_m;
  int          n_chk, n_bad;
  int          p_valid, p_ready, p_dma, p_srst, p_clr;

  task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic reset_model();
    inflight.delete();
    bufq.delete();
    credits     = DEPTH;
    drain_until = -1;
    last_accept = -100;
    busy_m      = 1'b0;
    err_m       = 1'b0;
  endtask

  task automatic step(input bit force_srst);
    bit drain_now, exp_ready, acc, oor, exp_en, pop, busy_nxt;
    @(posedge clk);
    #1;
    srst      = force_srst || ($urandom_range(0, 99) < p_srst);
    dma_reset = ($urandom_range(0, 99) < p_dma);
    req_valid = ($urandom_range(0, 99) < p_valid);
    t0_ready  = ($urandom_range(0, 99) < p_ready);
    err_clear = ($urandom_range(0, 99) < p_clr);
    if ($urandom_range(0, 9) == 0)
      req_addr = ($urandom_range(0, 1) == 0) ? WORDS + $urandom_range(0, 2047) : $urandom();
    else
      req_addr = $urandom_range(0, WORDS - 1);
    @(negedge clk);

    drain_now = (cyc <= drain_until);
    exp_ready = (credits != 0) && !dma_reset && !drain_now && !srst;
    acc       = req_valid && exp_ready;
    oor       = CheckEn && (req_addr >= WORDS);
    exp_en    = acc && !oor;

    check_eq("req_ready", req_ready, exp_ready);
    check_eq("mem_en", mem_en, exp_en);
    if (exp_en) check_eq("mem_addr", mem_addr, req_addr[AW-1:0]);
    check_eq("t0_valid", t0_valid, bufq.size() != 0);
    if (bufq.size() != 0) check_eq("t0_data", t0_data, bufq[0]);
    check_eq("busy", busy, busy_m);
    check_eq("err_addr", err_addr, err_m);

    pop = (bufq.size() != 0) && t0_ready;
    if (srst) begin
      reset_model();
    end else begin
      busy_nxt = acc || (inflight.size() != 0) || (bufq.size() != 0);
      if (CheckEn) begin
        if (acc && oor) err_m = 1'b1;
        else if (err_clear) err_m = 1'b0;
      end
      if (dma_reset) begin
        bufq.delete();
        credits = DEPTH;
        if (!drain_now && inflight.size() != 0) drain_until = last_accept + LAT + 1;
        inflight.delete();
        busy_nxt = (cyc + 1 <= drain_until);
      end else begin
        if (pop) void'(bufq.pop_front());
        if (inflight.size() != 0 && inflight[0].exit_cyc == cyc) begin
          bufq.push_back(inflight[0].data);
          void'(inflight.pop_front());
        end
        if (acc) begin
          inflight.push_back('{oor ? 32'h0 : sram_word(req_addr[15:0]), cyc + LAT});
          last_accept = cyc;
        end
        if (acc && !pop) credits--;
        else if (pop && !acc) credits++;
        busy_nxt = busy_nxt || (cyc + 1 <= drain_until);
      end
      busy_m = busy_nxt;
    end
    cyc++;
  endtask

  initial begin
    srst      = 1'b1;
    dma_reset = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    t0_ready  = 1'b0;
    err_clear = 1'b0;
    n_chk     = 0;
    n_bad     = 0;
    cyc       = 0;
    p_valid = 0; p_ready = 0; p_dma = 0; p_srst = 0; p_clr = 0;
    repeat (3) @(posedge clk);
    reset_model();

    step(1'b1);
    step(1'b1);
    for (int ph = 0; ph < 7; ph++) begin
      case (ph)
        0: begin p_valid = 100; p_ready = 100; p_dma = 0; p_srst = 0; p_clr = 0; end
        1: begin p_valid = 100; p_ready = 0;   p_dma = 0; p_srst = 0; p_clr = 0; end
        2: begin p_valid = 100; p_ready = 8;   p_dma = 0; p_srst = 0; p_clr = 10; end
        3: begin p_valid = 70;  p_ready = 50;  p_dma = 3; p_srst = 0; p_clr = 5; end
        4: begin p_valid = 90;  p_ready = 30;  p_dma = 5; p_srst = 0; p_clr = 3; end
        5: begin p_valid = 60;  p_ready = 70;  p_dma = 2; p_srst = 2; p_clr = 5; end
        default: begin p_valid = 100; p_ready = 100; p_dma = 1; p_srst = 0; p_clr = 2; end
      endcase
      for (int k = 0; k < 400; k++) step(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
